// File: rtl/multi_trig_pulse_gen.sv
// N-channel rising-edge triggered delayed-pulse generator with per-channel enable and retrigger.
// Define TRIG_MISS_CNT_EN to add per-channel saturating missed-trigger counters (miss_cnt_o).
module multi_trig_pulse_gen #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MW          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      trig_i,
  input  logic [N_CH-1:0]      enable_i,
  input  logic [N_CH-1:0]      retrig_i,
  input  logic [N_CH*CW-1:0]   delay_i,
  input  logic [N_CH*CW-1:0]   duration_i,
  output logic [N_CH-1:0]      pulse_o,
  output logic [N_CH-1:0]      busy_o,
  output logic [N_CH-1:0]      done_o
`ifdef TRIG_MISS_CNT_EN
  ,
  output logic [N_CH*MW-1:0]   miss_cnt_o
`endif
);

  typedef enum logic [1:0] {StIdle, StDelay, StActive} state_e;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d, fill_q, fill_d;
    logic                   hist_q, hist_d;
    logic                   sync_out, edge_det, finishing, start;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, dur_q, dur_d, ld_delay, ld_dur;
    logic                   retrig_q, retrig_d;
    logic                   pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;

    assign ld_delay = delay_i[k*CW +: CW];
    assign ld_dur   = duration_i[k*CW +: CW];
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_out & ~hist_q & enable_i[k];

    // History is held high until the synchroniser has refilled after reset, so a trigger
    // already high when reset is released is never seen as an edge.
    always_comb begin
      sync_d = SYNC_STAGES'({sync_q, trig_i[k]});
      fill_d = SYNC_STAGES'({fill_q, 1'b1});
      hist_d = fill_q[SYNC_STAGES-1] ? sync_out : 1'b1;
    end

    assign finishing = ((state_q == StActive) && (cnt_q == CW'(1))) ||
                       ((state_q == StDelay) && (cnt_q == CW'(1)) && (dur_q == '0));

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dur_d    = dur_q;
      retrig_d = retrig_q;
      done_d   = 1'b0;
      start    = edge_det && ((state_q == StIdle) || finishing || retrig_q);
      if (!enable_i[k]) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StDelay: begin
            if (cnt_q == CW'(1)) begin
              if (dur_q == '0) begin
                state_d = StIdle;
                done_d  = 1'b1;
              end else begin
                state_d = StActive;
                cnt_d   = dur_q;
              end
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          StActive: begin
            if (cnt_q == CW'(1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          default: ;
        endcase
        // A new trigger overrides whatever the count logic decided above.
        if (start) begin
          retrig_d = retrig_i[k];
          dur_d    = ld_dur;
          if (ld_delay != '0) begin
            state_d = StDelay;
            cnt_d   = ld_delay;
          end else if (ld_dur != '0) begin
            state_d = StActive;
            cnt_d   = ld_dur;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      pulse_d = (state_d == StActive);
      busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q   <= '0;
        fill_q   <= '0;
        hist_q   <= 1'b1;
        state_q  <= StIdle;
        cnt_q    <= '0;
        dur_q    <= '0;
        retrig_q <= 1'b0;
        pulse_q  <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        fill_q   <= fill_d;
        hist_q   <= hist_d;
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        dur_q    <= dur_d;
        retrig_q <= retrig_d;
        pulse_q  <= pulse_d;
        busy_q   <= busy_d;
        done_q   <= done_d;
      end
    end

    assign pulse_o[k] = pulse_q;
    assign busy_o[k]  = busy_q;
    assign done_o[k]  = done_q;

`ifdef TRIG_MISS_CNT_EN
    logic          miss_inc;
    logic [MW-1:0] miss_q, miss_d;

    assign miss_inc = edge_det && busy_q && !finishing && !retrig_q;

    always_comb begin
      miss_d = miss_q;
      if (miss_inc && (miss_q != {MW{1'b1}})) begin
        miss_d = miss_q + MW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        miss_q <= '0;
      end else begin
        miss_q <= miss_d;
      end
    end

    assign miss_cnt_o[k*MW +: MW] = miss_q;
`endif
  end

endmodule
